// File: rtl/pipe_collision_scorer.sv
// Collision / pass scorer: registers pipe and bird positions, then judges
// pipe-body, ground and ceiling crashes and pipe passes, and runs the
// IDLE / PLAY / LOST game-over state machine.
module pipe_collision_scorer #(
    parameter int BIRD_X    = 160,
    parameter int BIRD_W    = 16,
    parameter int BIRD_H    = 16,
    parameter int PIPE_W    = 52,
    parameter int GAP_H     = 120,
    parameter int SCREEN_W  = 640,
    parameter int SCREEN_H  = 480,
    parameter int SCORE_MAX = 999
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic [9:0] PipePosX,
    input  logic [9:0] PipePosY,
    input  logic [9:0] BirdPosY,
    output logic       Lost,
    output logic [9:0] Score,
    output logic       ScoreTick
);
    typedef enum logic [1:0] {IDLE, PLAY, LOST} state_t;

    // 11-bit constants so X+PIPE_W (up to 1075) never wraps
    localparam logic [10:0] C_BIRD_X   = 11'(BIRD_X);
    localparam logic [10:0] C_BIRD_XR  = 11'(BIRD_X + BIRD_W);
    localparam logic [10:0] C_BIRD_H   = 11'(BIRD_H);
    localparam logic [10:0] C_PIPE_W   = 11'(PIPE_W);
    localparam logic [10:0] C_GAP_H    = 11'(GAP_H);
    localparam logic [10:0] C_SCREEN_W = 11'(SCREEN_W);
    localparam logic [10:0] C_SCREEN_H = 11'(SCREEN_H);
    localparam logic [9:0]  C_SCORE_MX = 10'(SCORE_MAX);

    state_t     state, state_nxt;
    logic [9:0] x1, py1, by1, prevx;
    logic       passed, passed_nxt;
    logic [9:0] score_nxt;
    logic       tick_nxt;

    logic [10:0] xe, pxr, bye, byb;
    logic        xov, ingap, hit, newp, pass;

    // Stage 1: sample positions; prevx keeps the previous sample for wrap detection
    always_ff @(posedge Clk) begin
        if (Reset) begin
            x1    <= '0;
            py1   <= '0;
            by1   <= '0;
            prevx <= 10'd1023;
        end else begin
            x1    <= PipePosX;
            py1   <= PipePosY;
            by1   <= BirdPosY;
            prevx <= x1;
        end
    end

    // Stage 2 geometry on the registered sample
    always_comb begin
        xe    = {1'b0, x1};
        pxr   = xe + C_PIPE_W;
        bye   = {1'b0, by1};
        byb   = bye + C_BIRD_H;
        xov   = (xe < C_SCREEN_W) && (xe < C_BIRD_XR) && (pxr > C_BIRD_X);
        ingap = (by1 >= py1) && (byb <= ({1'b0, py1} + C_GAP_H));
        hit   = (xov && !ingap) || (byb >= C_SCREEN_H) || (by1 == 10'd0);
        // X jumping upward means a fresh pipe (wrap to 1000 or idle 1023 load)
        newp  = (x1 > prevx);
        pass  = !passed && !newp && (pxr < C_BIRD_X);
    end

    // Next-state, score and pass-flag decisions
    always_comb begin
        state_nxt  = state;
        score_nxt  = Score;
        tick_nxt   = 1'b0;
        passed_nxt = newp ? 1'b0 : passed;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt  = PLAY;
                    score_nxt  = '0;
                    passed_nxt = 1'b0;
                end
            end
            PLAY: begin
                // Start drop wins over a crash; a crash wins over a pass
                if (!Start) begin
                    state_nxt = IDLE;
                end else if (hit) begin
                    state_nxt = LOST;
                end else if (pass) begin
                    passed_nxt = 1'b1;
                    tick_nxt   = 1'b1;
                    score_nxt  = (Score >= C_SCORE_MX) ? C_SCORE_MX : Score + 10'd1;
                end
            end
            LOST: begin
                if (!Start) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 2 state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            Score     <= '0;
            ScoreTick <= 1'b0;
            passed    <= 1'b0;
        end else begin
            state     <= state_nxt;
            Score     <= score_nxt;
            ScoreTick <= tick_nxt;
            passed    <= passed_nxt;
        end
    end

    assign Lost = (state == LOST);

endmodule

// File: tb/tb_pipe_collision_scorer.sv
// Scoreboard bench: every stimulus cycle pushes the expected outputs from a
// rule-level game model; a separate monitor pops and compares each cycle.
module tb_pipe_collision_scorer;
    logic       Clk = 1'b0;
    logic       Reset, Start;
    logic [9:0] PipePosX, PipePosY, BirdPosY;
    logic       Lost, ScoreTick;
    logic [9:0] Score;

    pipe_collision_scorer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .PipePosX(PipePosX), .PipePosY(PipePosY), .BirdPosY(BirdPosY),
        .Lost(Lost), .Score(Score), .ScoreTick(ScoreTick)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       lost;
        logic [9:0] score;
        logic       tick;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    string tag = "init";

    // Reference game model: what was seen one cycle ago decides this cycle
    int  m_mode;          // 0 idle, 1 playing, 2 crashed
    int  m_score;
    bit  m_tick;
    bit  m_credited;      // current pipe already scored
    int  h_x, h_py, h_by; // positions presented last cycle
    int  h_prev;          // positions presented two cycles ago (X only)

    task automatic model_reset();
        m_mode = 0; m_score = 0; m_tick = 0; m_credited = 0;
        h_x = 0; h_py = 0; h_by = 0; h_prev = 1023;
    endtask

    task automatic model_clock(input bit rst, input bit st, input int x, input int py, input int by);
        bit crash, fresh, scored, overlap, safe;
        if (rst) begin
            model_reset();
            return;
        end
        overlap = (h_x < 640) && (h_x < 176) && (h_x + 52 > 160);
        safe    = (h_by >= h_py) && (h_by + 16 <= h_py + 120);
        crash   = (overlap && !safe) || (h_by + 16 >= 480) || (h_by == 0);
        fresh   = h_x > h_prev;
        scored  = !m_credited && !fresh && (h_x + 52 < 160);
        m_tick  = 0;
        if (fresh) m_credited = 0;
        if (m_mode == 0) begin
            if (st) begin m_mode = 1; m_score = 0; m_credited = 0; end
        end else if (m_mode == 1) begin
            if (!st) m_mode = 0;
            else if (crash) m_mode = 2;
            else if (scored) begin
                m_credited = 1;
                m_tick = 1;
                if (m_score < 999) m_score++;
            end
        end else begin
            if (!st) m_mode = 0;
        end
        h_prev = h_x;
        h_x = x; h_py = py; h_by = by;
    endtask

    // One clock of stimulus; expectation pushed right after the edge
    task automatic cyc(input bit rst, input bit st, input int x, input int py, input int by);
        exp_t e;
        Reset = rst; Start = st;
        PipePosX = 10'(x); PipePosY = 10'(py); BirdPosY = 10'(by);
        @(posedge Clk);
        model_clock(rst, st, x, py, by);
        e.lost = (m_mode == 2); e.score = 10'(m_score); e.tick = m_tick; e.tag = tag;
        exp_q.push_back(e);
        @(negedge Clk);
    endtask

    // Monitor: outputs are presented every cycle
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if (Lost !== e.lost || Score !== e.score || ScoreTick !== e.tick) begin
                n_fail++;
                $display("FAIL %s: got Lost=%0b Score=%0d Tick=%0b, want Lost=%0b Score=%0d Tick=%0b",
                         e.tag, Lost, Score, ScoreTick, e.lost, e.score, e.tick);
            end
        end
    end

    initial begin
        int wait_cnt;
        model_reset();
        Reset = 1; Start = 0; PipePosX = 0; PipePosY = 0; BirdPosY = 0;
        @(negedge Clk);

        tag = "T1_reset";
        repeat (3) cyc(1, 1, 100, 200, 250);

        tag = "T2_sweep";
        repeat (3) cyc(0, 0, 300, 200, 250);
        for (int x = 300; x >= 0; x--) cyc(0, 1, x, 200, 250);
        repeat (3) cyc(0, 1, 0, 200, 250);

        tag = "T3_pipe_hit";
        repeat (3) cyc(0, 0, 300, 200, 190);
        cyc(0, 1, 150, 200, 190);
        for (int x = 150; x >= 0; x -= 2) cyc(0, 1, x, 200, 190);
        repeat (3) cyc(0, 0, 0, 200, 250);

        tag = "T4_ground";
        repeat (2) cyc(0, 0, 1023, 200, 464);
        repeat (4) cyc(0, 1, 1023, 200, 464);
        repeat (3) cyc(0, 0, 1023, 200, 463);
        repeat (6) cyc(0, 1, 1023, 200, 463);
        repeat (2) cyc(0, 0, 1023, 200, 250);

        tag = "T5_two_sweeps";
        repeat (3) cyc(0, 1, 1023, 200, 250);
        for (int k = 0; k < 2; k++)
            for (int x = 1000; x >= 0; x -= 3) cyc(0, 1, x, 200, 250);
        repeat (3) cyc(0, 1, 1023, 200, 250);

        tag = "T6_saturate";
        cyc(1, 0, 1023, 200, 250);
        repeat (2) cyc(0, 0, 1023, 200, 250);
        for (int i = 0; i < 1001; i++) begin
            cyc(0, 1, 1023, 200, 250);
            cyc(0, 1, 100, 200, 250);
        end
        repeat (2) cyc(0, 1, 100, 200, 250);
        cyc(1, 1, 1023, 200, 250);
        repeat (3) cyc(0, 0, 1023, 200, 250);

        tag = "random";
        for (int i = 0; i < 600; i++) begin
            int by;
            case ($urandom_range(0, 9))
                0:       by = 0;
                1:       by = 463 + $urandom_range(0, 2);
                default: by = $urandom_range(1, 470);
            endcase
            cyc(0, ($urandom_range(0, 24) != 0), $urandom_range(0, 1023),
                $urandom_range(0, 359), by);
        end

        tag = "random_sweep";
        for (int i = 0; i < 600; i++) begin
            int x;
            x = 1000 - (i * 7) % 1001;
            cyc(0, ($urandom_range(0, 99) != 0), x, 200, 200 + $urandom_range(0, 104));
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge Clk);
            wait_cnt++;
        end
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
